led_wr_arbiter: RTL

//  Arbitrates two write requesters for the 8x8x4-bit LED frame-buffer RAM write port:
//   - requester 0: light-pen hit writer
//   - requester 1: pattern/game engine

---
 rtl/led_wr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/led_wr_arbiter.sv
// led_wr_arbiter: arbitrates two writers onto the LED frame-buffer RAM's edge-triggered write port
// Optional feature: define LED_WR_ARB_RR_EN for round-robin arbitration (default fixed priority, req0 first)
module led_wr_arbiter #(
   parameter int WE_HI_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       state,
   input  logic       req0_valid,
   input  logic [2:0] req0_row,
   input  logic [2:0] req0_col,
   input  logic [3:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [2:0] req1_row,
   input  logic [2:0] req1_col,
   input  logic [3:0] req1_data,
   output logic       req1_ready,
   output logic       ram_we,
   output logic [7:0] ram_addr_row,
   output logic [7:0] ram_addr_col,
   output logic [3:0] ram_data,
   output logic       busy,
   output logic       grant_id,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, SETUP, WE_HI, WE_LO} st_t;
   st_t st, nxt;
   logic [7:0] cnt;
   logic last_grant, state_q, g0, g1, acc;
   logic unused_ok;
   // the RAM clears itself on a mode change, so the tracked mode never alters the write path
   assign unused_ok = state ^ state_q ^ last_grant;
   // pick a requester; the choice only takes effect when an accept happens
   always_comb begin
`ifdef LED_WR_ARB_RR_EN
      g1 = req1_valid && (!req0_valid || !last_grant);
`else
      g1 = req1_valid && !req0_valid;
`endif
      g0 = req0_valid && !g1;
      acc = rst_n && st == IDLE && (g0 || g1);
   end
   // state register with per-state cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st <= IDLE;
         cnt <= '0;
      end else begin
         st <= nxt;
         cnt <= (st != nxt) ? '0 : cnt + 8'd1;
      end
   end
   // next-state sequencing: SETUP, we high, we low gap, back to IDLE
   always_comb begin
      nxt = st;
      case (st)
         IDLE:  nxt = acc ? SETUP : IDLE;
         SETUP: nxt = WE_HI;
         WE_HI: nxt = (cnt == 8'(WE_HI_CYC - 1)) ? WE_LO : WE_HI;
         WE_LO: nxt = (cnt == 8'(GAP_CYC - 1)) ? IDLE : WE_LO;
         default: nxt = IDLE;
      endcase
   end
   // registered RAM drive: payload captured at accept, we follows the FSM one edge ahead
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_we <= 1'b0;
         ram_addr_row <= '0;
         ram_addr_col <= '0;
         ram_data <= '0;
         grant_id <= 1'b0;
         last_grant <= 1'b1;
         state_q <= state;
      end else begin
         ram_we <= nxt == WE_HI;
         state_q <= state;
         if (acc) begin
            ram_addr_row <= 8'b1 << (g1 ? req1_row : req0_row);
            ram_addr_col <= 8'b1 << (g1 ? req1_col : req0_col);
            ram_data <= g1 ? req1_data : req0_data;
            grant_id <= g1;
            last_grant <= g1;
         end
      end
   end
   // status and handshake outputs
   always_comb begin
      busy = st != IDLE;
      done = st == WE_LO && cnt == '0;
      req0_ready = acc && g0;
      req1_ready = acc && g1;
   end
endmodule
